oven_sequencer: RTL and testbench

- Front-end controller that sequences the countdown timer block for a microwave-style appliance.
- Owns the time setting (presets plus +30 s increments), the door interlock, the heater and lamp enables, and the end-of-cycle beep.
- Drives the timer's start/stop/pause inputs with one-cycle pulses and its min/sec inputs with the configured time.
- Watches the timer's done output to detect completion.

---
 rtl/oven_pkg.sv | 16 +
 rtl/rise_detect_n.sv | 25 ++
 rtl/oven_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_oven_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oven_pkg.sv
// Shared definitions for the oven front-end sequencer: state encodings and
// the limits of the configured cooking time.
package oven_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COOKING = 3'd1,
        PAUSED  = 3'd2,
        FINISH  = 3'd3
    } state_e;

    localparam int MAX_MIN  = 99;
    localparam int MAX_SEC  = 59;
    localparam int ADD_STEP = 30;

endpackage

// File: rtl/rise_detect_n.sv
// Single-bit rising-edge detector: registers the input each clock and flags
// the cycle in which the newest sample is high and the one before it was low.
module rise_detect_n (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic sample_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sample_q <= d_i;
            prev_q   <= sample_q;
        end
    end

    assign rise_o = sample_q & ~prev_q;

endmodule

// File: rtl/oven_sequencer.sv
// Microwave front-end controller: owns the time setting, door interlock,
// heater/lamp/beep, and sequences the countdown timer with one-cycle pulses.
module oven_sequencer
    import oven_pkg::*;
#(
    parameter int BEEP_CYCLES = 150000000,
    parameter int PRESET0_MIN = 2,
    parameter int PRESET0_SEC = 0,
    parameter int PRESET1_MIN = 1,
    parameter int PRESET1_SEC = 30,
    parameter int PRESET2_MIN = 5,
    parameter int PRESET2_SEC = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_add30,
    input  logic [2:0] btn_preset,
    input  logic       door_open,
    input  logic       timer_done,
    output logic       tmr_start,
    output logic       tmr_stop,
    output logic       tmr_pause,
    output logic [6:0] min_cfg,
    output logic [6:0] sec_cfg,
    output logic       heater_on,
    output logic       lamp_on,
    output logic       beep,
    output logic [2:0] state_dbg
);

    localparam int CNT_W = $clog2(BEEP_CYCLES + 1);

    state_e           state_q, state_d;
    logic [6:0]       min_q, min_d;
    logic [6:0]       sec_q, sec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             pause_q, pause_d;
    logic             heater_q, lamp_q, beep_q;
    logic             door_q;
    logic             done_s_q, done_p_q;

    logic       start_r, stop_r, add_r, door_r;
    logic [2:0] preset_r;
    logic       done_r, busy, any_evt, cfg_zero;
    logic [6:0] add_min, add_sec;
    logic       heater_d;

    rise_detect_n u_rd_start  (.clk_i(clock), .rst_ni(reset), .d_i(btn_start),     .rise_o(start_r));
    rise_detect_n u_rd_stop   (.clk_i(clock), .rst_ni(reset), .d_i(btn_stop),      .rise_o(stop_r));
    rise_detect_n u_rd_add30  (.clk_i(clock), .rst_ni(reset), .d_i(btn_add30),     .rise_o(add_r));
    rise_detect_n u_rd_door   (.clk_i(clock), .rst_ni(reset), .d_i(door_open),     .rise_o(door_r));
    rise_detect_n u_rd_pre0   (.clk_i(clock), .rst_ni(reset), .d_i(btn_preset[0]), .rise_o(preset_r[0]));
    rise_detect_n u_rd_pre1   (.clk_i(clock), .rst_ni(reset), .d_i(btn_preset[1]), .rise_o(preset_r[1]));
    rise_detect_n u_rd_pre2   (.clk_i(clock), .rst_ni(reset), .d_i(btn_preset[2]), .rise_o(preset_r[2]));

    // Door level and timer_done history share the button sampling latency.
    assign done_r   = done_s_q & ~done_p_q;
    assign busy     = start_q | stop_q | pause_q;
    assign any_evt  = start_r | stop_r | add_r | door_r | (|preset_r);
    assign cfg_zero = (min_q == 7'd0) && (sec_q == 7'd0);

    always_comb begin
        add_min = min_q;
        add_sec = sec_q;
        if (min_q == 7'(MAX_MIN) && sec_q >= 7'(MAX_SEC + 1 - ADD_STEP)) begin
            add_sec = 7'(MAX_SEC);
        end else if (sec_q >= 7'(MAX_SEC + 1 - ADD_STEP)) begin
            add_min = min_q + 7'd1;
            add_sec = sec_q - 7'(MAX_SEC + 1 - ADD_STEP);
        end else begin
            add_sec = sec_q + 7'(ADD_STEP);
        end
    end

    // The cycle after any timer pulse ignores events, so pulses never abut;
    // every COOKING entry carries tmr_start, which also masks timer_done then.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        stop_d  = 1'b0;
        pause_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!busy) begin
                    if (stop_r) begin
                        min_d = '0;
                        sec_d = '0;
                    end else if (!door_r) begin
                        if (start_r) begin
                            if (!door_q && !cfg_zero) begin
                                start_d = 1'b1;
                                state_d = COOKING;
                            end
                        end else if (preset_r[0]) begin
                            min_d = 7'(PRESET0_MIN);
                            sec_d = 7'(PRESET0_SEC);
                        end else if (preset_r[1]) begin
                            min_d = 7'(PRESET1_MIN);
                            sec_d = 7'(PRESET1_SEC);
                        end else if (preset_r[2]) begin
                            min_d = 7'(PRESET2_MIN);
                            sec_d = 7'(PRESET2_SEC);
                        end else if (add_r) begin
                            min_d = add_min;
                            sec_d = add_sec;
                        end
                    end
                end
            end
            COOKING: begin
                if (!busy) begin
                    if (stop_r) begin
                        stop_d  = 1'b1;
                        min_d   = '0;
                        sec_d   = '0;
                        state_d = IDLE;
                    end else if (door_q) begin
                        pause_d = 1'b1;
                        state_d = PAUSED;
                    end else if (done_r) begin
                        cnt_d   = '0;
                        state_d = FINISH;
                    end
                end
            end
            PAUSED: begin
                if (!busy) begin
                    if (stop_r) begin
                        stop_d  = 1'b1;
                        min_d   = '0;
                        sec_d   = '0;
                        state_d = IDLE;
                    end else if (!door_r && start_r && !door_q) begin
                        start_d = 1'b1;
                        state_d = COOKING;
                    end
                end
            end
            FINISH: begin
                if (any_evt || cnt_q == CNT_W'(BEEP_CYCLES - 1)) begin
                    min_d   = '0;
                    sec_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Heater drops on the very edge the door is seen open, whatever the state.
    assign heater_d = (state_d == COOKING) && !door_open;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            min_q    <= '0;
            sec_q    <= '0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            pause_q  <= 1'b0;
            heater_q <= 1'b0;
            lamp_q   <= 1'b0;
            beep_q   <= 1'b0;
            door_q   <= 1'b0;
            done_s_q <= 1'b0;
            done_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            pause_q  <= pause_d;
            heater_q <= heater_d;
            lamp_q   <= door_open | heater_d;
            beep_q   <= (state_d == FINISH);
            door_q   <= door_open;
            done_s_q <= timer_done;
            done_p_q <= done_s_q;
        end
    end

    assign tmr_start = start_q;
    assign tmr_stop  = stop_q;
    assign tmr_pause = pause_q;
    assign min_cfg   = min_q;
    assign sec_cfg   = sec_q;
    assign heater_on = heater_q;
    assign lamp_on   = lamp_q;
    assign beep      = beep_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_oven_sequencer.sv
// Self-checking bench for oven_sequencer: directed scenarios with literal
// expectations plus a randomized run against a time-in-seconds reference model.
module tb_oven_sequencer;

    localparam int BEEP     = 20;
    localparam int M_IDLE   = 0;
    localparam int M_COOK   = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_FINISH = 3;
    localparam int MAX_T    = 99 * 60 + 59;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0, btn_stop = 1'b0, btn_add30 = 1'b0;
    logic [2:0] btn_preset = 3'b000;
    logic       door_open = 1'b0, timer_done = 1'b0;
    logic       tmr_start, tmr_stop, tmr_pause;
    logic [6:0] min_cfg, sec_cfg;
    logic       heater_on, lamp_on, beep;
    logic [2:0] state_dbg;

    oven_sequencer #(.BEEP_CYCLES(BEEP)) dut (
        .clock(clk), .reset(rst_n),
        .btn_start(btn_start), .btn_stop(btn_stop), .btn_add30(btn_add30),
        .btn_preset(btn_preset), .door_open(door_open), .timer_done(timer_done),
        .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_pause(tmr_pause),
        .min_cfg(min_cfg), .sec_cfg(sec_cfg),
        .heater_on(heater_on), .lamp_on(lamp_on), .beep(beep),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;
    int nStart = 0, nStop = 0, nPause = 0;

    task automatic checkOutput(input string name, input int act, input int exp);
        assertCount++;
        if (act != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: configured time kept as total seconds, beep as a
    // remaining-cycle countdown, inputs as the last two edge samples.
    int       mMode = 0, mTime = 0, mBeepLeft = 0;
    bit       mStart = 0, mStop = 0, mPause = 0, mHeater = 0, mLamp = 0, mBeep = 0;
    bit [6:0] h1 = '0, h2 = '0;
    bit       d1 = 0, d2 = 0;
    bit [6:0] ev;
    bit       evDone, busy, doorLvl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMode = M_IDLE; mTime = 0; mBeepLeft = 0;
            mStart = 0; mStop = 0; mPause = 0; mHeater = 0; mLamp = 0; mBeep = 0;
            h1 = '0; h2 = '0; d1 = 0; d2 = 0;
        end else begin
            ev      = h1 & ~h2;
            evDone  = d1 & ~d2;
            doorLvl = h1[3];
            busy    = mStart | mStop | mPause;
            mStart = 0; mStop = 0; mPause = 0;
            case (mMode)
                M_IDLE: if (!busy) begin
                    if (ev[1]) mTime = 0;
                    else if (!ev[3]) begin
                        if (ev[0]) begin
                            if (!doorLvl && mTime != 0) begin mStart = 1; mMode = M_COOK; end
                        end
                        else if (ev[4]) mTime = 120;
                        else if (ev[5]) mTime = 90;
                        else if (ev[6]) mTime = 300;
                        else if (ev[2]) mTime = (mTime + 30 > MAX_T) ? MAX_T : mTime + 30;
                    end
                end
                M_COOK: if (!busy) begin
                    if (ev[1]) begin mStop = 1; mTime = 0; mMode = M_IDLE; end
                    else if (doorLvl) begin mPause = 1; mMode = M_PAUSE; end
                    else if (evDone) begin mMode = M_FINISH; mBeepLeft = BEEP; end
                end
                M_PAUSE: if (!busy) begin
                    if (ev[1]) begin mStop = 1; mTime = 0; mMode = M_IDLE; end
                    else if (!ev[3] && ev[0] && !doorLvl) begin mStart = 1; mMode = M_COOK; end
                end
                default: begin
                    if ((|ev) || mBeepLeft == 1) begin mMode = M_IDLE; mTime = 0; end
                    else mBeepLeft--;
                end
            endcase
            h2 = h1;
            h1 = {btn_preset, door_open, btn_add30, btn_stop, btn_start};
            d2 = d1;
            d1 = timer_done;
            mHeater = (mMode == M_COOK) && !door_open;
            mLamp   = door_open | mHeater;
            mBeep   = (mMode == M_FINISH);
        end
    end

    always @(posedge clk) begin
        #1;
        checkOutput("state", int'(state_dbg), mMode);
        checkOutput("min_cfg", int'(min_cfg), mTime / 60);
        checkOutput("sec_cfg", int'(sec_cfg), mTime % 60);
        checkOutput("tmr_start", int'(tmr_start), int'(mStart));
        checkOutput("tmr_stop", int'(tmr_stop), int'(mStop));
        checkOutput("tmr_pause", int'(tmr_pause), int'(mPause));
        checkOutput("heater_on", int'(heater_on), int'(mHeater));
        checkOutput("lamp_on", int'(lamp_on), int'(mLamp));
        checkOutput("beep", int'(beep), int'(mBeep));
        if (tmr_start) nStart++;
        if (tmr_stop)  nStop++;
        if (tmr_pause) nPause++;
    end

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setBtn(input int which, input logic val);
        case (which)
            0: btn_start = val;
            1: btn_stop  = val;
            2: btn_add30 = val;
            3: btn_preset[0] = val;
            4: btn_preset[1] = val;
            default: btn_preset[2] = val;
        endcase
    endtask

    task automatic press(input int which);
        @(negedge clk);
        setBtn(which, 1'b1);
        waitNeg(2);
        setBtn(which, 1'b0);
        waitNeg(2);
    endtask

    function automatic logic nextLevel(input logic cur, input int riseOdds);
        if (cur) return ($urandom_range(2) != 0);
        return ($urandom_range(riseOdds - 1) == 0);
    endfunction

    task automatic applyStimulus();
        @(negedge clk);
        btn_start     = nextLevel(btn_start, 10);
        btn_stop      = nextLevel(btn_stop, 60);
        btn_add30     = nextLevel(btn_add30, 12);
        btn_preset[0] = nextLevel(btn_preset[0], 40);
        btn_preset[1] = nextLevel(btn_preset[1], 40);
        btn_preset[2] = nextLevel(btn_preset[2], 40);
        if (door_open) door_open = ($urandom_range(7) != 0);
        else           door_open = ($urandom_range(49) == 0);
        timer_done    = nextLevel(timer_done, 25);
    endtask

    int s0, p0, st0;
    int expSecs[4] = '{30, 60, 90, 120};

    initial begin
        waitNeg(3);
        checkOutput("rst_state", int'(state_dbg), 0);
        checkOutput("rst_min", int'(min_cfg), 0);
        checkOutput("rst_heater", int'(heater_on), 0);
        rst_n = 1'b1;
        waitNeg(2);

        press(4);
        checkOutput("preset1_min", int'(min_cfg), 1);
        checkOutput("preset1_sec", int'(sec_cfg), 30);

        @(negedge clk) btn_start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("start_pulse", int'(tmr_start), 1);
        checkOutput("start_state", int'(state_dbg), M_COOK);
        checkOutput("start_heater", int'(heater_on), 1);
        @(posedge clk);
        #1 checkOutput("start_pulse_width", int'(tmr_start), 0);
        @(negedge clk) btn_start = 1'b0;
        waitNeg(3);

        @(negedge clk) door_open = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("door_heater_off", int'(heater_on), 0);
        checkOutput("door_lamp_on", int'(lamp_on), 1);
        @(posedge clk);
        #1;
        checkOutput("door_pause_pulse", int'(tmr_pause), 1);
        checkOutput("door_paused", int'(state_dbg), M_PAUSE);
        @(negedge clk) door_open = 1'b0;
        waitNeg(5);
        checkOutput("close_stays_paused", int'(state_dbg), M_PAUSE);
        press(0);
        checkOutput("resume_state", int'(state_dbg), M_COOK);

        waitNeg(3);
        @(negedge clk) timer_done = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("finish_state", int'(state_dbg), M_FINISH);
        checkOutput("finish_beep", int'(beep), 1);
        repeat (BEEP - 1) @(posedge clk);
        #1 checkOutput("beep_last_cycle", int'(beep), 1);
        @(posedge clk);
        #1;
        checkOutput("beep_done", int'(beep), 0);
        checkOutput("beep_done_state", int'(state_dbg), M_IDLE);
        checkOutput("beep_done_min", int'(min_cfg), 0);
        checkOutput("beep_done_sec", int'(sec_cfg), 0);
        @(negedge clk) timer_done = 1'b0;

        for (int i = 0; i < 4; i++) begin
            press(2);
            checkOutput("add30_min", int'(min_cfg), expSecs[i] / 60);
            checkOutput("add30_sec", int'(sec_cfg), expSecs[i] % 60);
        end

        press(1);
        s0 = nStart;
        press(0);
        waitNeg(2);
        checkOutput("start_zero_state", int'(state_dbg), M_IDLE);
        checkOutput("start_zero_pulses", nStart - s0, 0);

        press(2);
        @(negedge clk) door_open = 1'b1;
        waitNeg(2);
        s0 = nStart;
        press(0);
        checkOutput("start_door_state", int'(state_dbg), M_IDLE);
        checkOutput("start_door_pulses", nStart - s0, 0);
        @(negedge clk) door_open = 1'b0;
        waitNeg(2);

        for (int i = 0; i < 198; i++) press(2);
        checkOutput("sat_pre_min", int'(min_cfg), 99);
        checkOutput("sat_pre_sec", int'(sec_cfg), 30);
        press(2);
        checkOutput("sat_sec", int'(sec_cfg), 59);
        press(2);
        checkOutput("sat_hold_min", int'(min_cfg), 99);
        checkOutput("sat_hold_sec", int'(sec_cfg), 59);

        press(0);
        waitNeg(3);
        @(negedge clk) timer_done = 1'b1;
        waitNeg(5);
        checkOutput("finish2_state", int'(state_dbg), M_FINISH);
        press(1);
        checkOutput("early_stop_state", int'(state_dbg), M_IDLE);
        checkOutput("early_stop_beep", int'(beep), 0);
        checkOutput("early_stop_min", int'(min_cfg), 0);
        @(negedge clk) timer_done = 1'b0;

        press(3);
        checkOutput("preset0_min", int'(min_cfg), 2);
        press(0);
        waitNeg(3);
        p0 = nPause;
        st0 = nStop;
        @(negedge clk);
        btn_stop  = 1'b1;
        door_open = 1'b1;
        waitNeg(4);
        checkOutput("stopdoor_state", int'(state_dbg), M_IDLE);
        checkOutput("stopdoor_min", int'(min_cfg), 0);
        checkOutput("stopdoor_stops", nStop - st0, 1);
        checkOutput("stopdoor_pauses", nPause - p0, 0);
        btn_stop  = 1'b0;
        door_open = 1'b0;
        waitNeg(3);

        press(5);
        checkOutput("preset2_min", int'(min_cfg), 5);
        press(0);
        waitNeg(3);
        checkOutput("precut_heater", int'(heater_on), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("cut_heater", int'(heater_on), 0);
        checkOutput("cut_lamp", int'(lamp_on), 0);
        checkOutput("cut_state", int'(state_dbg), 0);
        checkOutput("cut_min", int'(min_cfg), 0);
        checkOutput("cut_beep", int'(beep), 0);
        waitNeg(2);
        rst_n = 1'b1;
        waitNeg(2);

        repeat (3000) applyStimulus();
        @(negedge clk);
        btn_start = 1'b0; btn_stop = 1'b0; btn_add30 = 1'b0;
        btn_preset = 3'b000; door_open = 1'b0; timer_done = 1'b0;
        waitNeg(5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
